waveform_capture: RTL

//  Producer side of the oscilloscope display path: captures the audio stream into a

---
 rtl/scope_pkg.sv | 6 +
 rtl/scope_dpram.sv | 26 ++
 rtl/waveform_capture.sv | 115 +++++++++++
 3 files changed

// File: rtl/scope_pkg.sv
// Shared types and constants for the oscilloscope capture path.
package scope_pkg;
  typedef enum logic [1:0] {ARM, FILL, DONE} cap_state_t;
  localparam int SAMPLE_W  = 8;
  localparam int VISIBLE_W = 640;
endpackage

// File: rtl/scope_dpram.sv
// Simple dual-port sample store: two banks of NSAMP bytes, sync write, sync read.
module scope_dpram #(
  parameter int NSAMP = 640,
  parameter int IDX_W = 10,
  parameter int DW    = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             wbank_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic             re_i,
  input  logic             rbank_i,
  input  logic [IDX_W-1:0] ridx_i,
  output logic [DW-1:0]    rdata_o
);
  logic [DW-1:0] mem_q [2][NSAMP];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wbank_i][widx_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[rbank_i][ridx_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/waveform_capture.sv
// Triggered, decimated audio capture into a double-buffered store; replays one
// signed byte per pixel column. Banks swap only at frame start after a full capture.
module waveform_capture
  import scope_pkg::*;
#(
  parameter int AUDIO_W      = 16,
  parameter int NSAMP        = VISIBLE_W,
  parameter int DECIM        = 4,
  parameter int TRIG_TIMEOUT = 2048
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                sample_valid,
  input  logic [AUDIO_W-1:0]  sample_in,
  input  logic                frame_start,
  input  logic [9:0]          DrawX,
  output logic [SAMPLE_W-1:0] song_sample,
  output logic                capture_busy,
  output logic                frame_ready
);
  localparam int DC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int TO_W = (TRIG_TIMEOUT > 1) ? $clog2(TRIG_TIMEOUT) : 1;
  localparam logic [DC_W-1:0] DC_LAST   = DC_W'(DECIM - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TRIG_TIMEOUT - 1);
  localparam logic [9:0]      ADDR_LAST = 10'(NSAMP - 1);

  cap_state_t          state_q;
  logic [DC_W-1:0]     decim_q, decim_d;
  logic [TO_W-1:0]     timeout_q;
  logic [9:0]          wr_addr_q;
  logic                prev_neg_q, rd_bank_q, have_data_q, rd_ok_q;
  logic                busy_q, ready_q;

  logic [SAMPLE_W-1:0] s8, rdata;
  logic                kept, start, we, rd_in_range;
  logic [9:0]          widx;
  logic                unused_low;

  assign s8          = sample_in[AUDIO_W-1 -: SAMPLE_W];
  assign unused_low  = ^sample_in[AUDIO_W-SAMPLE_W-1:0];
  assign kept        = sample_valid && (decim_q == '0) && (state_q != DONE);
  assign start       = (prev_neg_q && !s8[SAMPLE_W-1]) || (timeout_q == TO_LAST);
  assign we          = kept && ((state_q == FILL) || (state_q == ARM && start));
  assign widx        = (state_q == ARM) ? 10'd0 : wr_addr_q;
  assign rd_in_range = (32'(DrawX) < 32'(NSAMP));
  assign decim_d     = (decim_q == DC_LAST) ? '0 : decim_q + 1'b1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ARM;
      decim_q     <= '0;
      timeout_q   <= '0;
      wr_addr_q   <= '0;
      prev_neg_q  <= 1'b0;
      rd_bank_q   <= 1'b0;
      have_data_q <= 1'b0;
      rd_ok_q     <= 1'b0;
      busy_q      <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      if (state_q != DONE && sample_valid) decim_q <= decim_d;
      case (state_q)
        ARM: if (kept) begin
          prev_neg_q <= s8[SAMPLE_W-1];
          if (start) begin
            wr_addr_q <= 10'd1;
            state_q   <= FILL;
          end else begin
            timeout_q <= timeout_q + 1'b1;
          end
        end
        FILL: if (kept) begin
          wr_addr_q <= wr_addr_q + 10'd1;
          if (wr_addr_q == ADDR_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        DONE: begin
          // A strobe coinciding with the swap is dropped: the counter restarts at 0.
          decim_q <= '0;
          if (frame_start) begin
            rd_bank_q   <= ~rd_bank_q;
            have_data_q <= 1'b1;
            wr_addr_q   <= '0;
            timeout_q   <= '0;
            prev_neg_q  <= 1'b0;
            state_q     <= ARM;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
          end
        end
        default: state_q <= ARM;
      endcase
      rd_ok_q <= have_data_q && rd_in_range;
    end
  end

  scope_dpram #(.NSAMP(NSAMP), .IDX_W(10), .DW(SAMPLE_W)) u_ram (
    .clk_i   (Clk),
    .we_i    (we),
    .wbank_i (~rd_bank_q),
    .widx_i  (widx),
    .wdata_i (s8),
    .re_i    (rd_in_range),
    .rbank_i (rd_bank_q),
    .ridx_i  (DrawX),
    .rdata_o (rdata)
  );

  assign song_sample  = rd_ok_q ? rdata : '0;
  assign capture_busy = busy_q;
  assign frame_ready  = ready_q;
endmodule
